// File: rtl/divider_fsm_if.sv
// divider_fsm_if: start/operand/result bundle for divider_fsm; o_divZero exists only with DIVIDER_FSM_DIVZERO_EN.
interface divider_fsm_if #(parameter int WIDTH = 8);
  logic i_cg;
  logic i_begin;
  logic [WIDTH-1:0] i_dividend;
  logic [WIDTH-1:0] i_divisor;
  logic o_busy;
  logic [WIDTH-1:0] o_quotient;
  logic [WIDTH-1:0] o_remainder;
`ifdef DIVIDER_FSM_DIVZERO_EN
  logic o_divZero;
`endif
  modport master (
    output i_cg, i_begin, i_dividend, i_divisor,
    input o_busy, o_quotient, o_remainder
`ifdef DIVIDER_FSM_DIVZERO_EN
    , input o_divZero
`endif
  );
  modport slave (
    input i_cg, i_begin, i_dividend, i_divisor,
    output o_busy, o_quotient, o_remainder
`ifdef DIVIDER_FSM_DIVZERO_EN
    , output o_divZero
`endif
  );
endinterface

// File: rtl/divider_fsm.sv
// divider_fsm: multi-cycle unsigned restoring divider (or timing-identical behavioural model).
// Optional DIVIDER_FSM_DIVZERO_EN adds the o_divZero flag.
module divider_fsm #(
  parameter int WIDTH = 8,
  parameter bit ABSTRACT_MODEL = 1'b0
) (
  input logic i_clk,
  input logic i_rst,
  divider_fsm_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] dvs, quo, quo_n, q_out, r_out, aq, ar;
  logic [WIDTH:0] rem, rem_n, sh;
  logic [WIDTH+1:0] trial;
  logic [CW-1:0] cnt;
  logic start, done;
`ifdef DIVIDER_FSM_DIVZERO_EN
  logic dz;
  assign bus.o_divZero = dz;
`endif
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) state <= IDLE;
    else if (bus.i_cg) state <= state_n;
  always_comb begin
    sh = {rem[WIDTH-1:0], quo[WIDTH-1]};
    trial = {1'b0, sh} - {2'b0, dvs};
    rem_n = trial[WIDTH+1] ? sh : trial[WIDTH:0];
    quo_n = {quo[WIDTH-2:0], ~trial[WIDTH+1]};
    start = state == IDLE && bus.i_begin;
    done = state == RUN && cnt == CW'(1);
    state_n = start ? RUN : done ? IDLE : state;
  end
  // Results land on the outputs in the same edge as the final restoring step.
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      dvs <= '0;
      quo <= '0;
      rem <= '0;
      cnt <= '0;
      aq <= '0;
      ar <= '0;
      q_out <= '0;
      r_out <= '0;
`ifdef DIVIDER_FSM_DIVZERO_EN
      dz <= 1'b0;
`endif
    end else if (bus.i_cg) begin
      if (start) begin
        dvs <= bus.i_divisor;
        quo <= bus.i_dividend;
        rem <= '0;
        cnt <= CW'(WIDTH);
        aq <= bus.i_divisor == '0 ? '1 : bus.i_dividend / bus.i_divisor;
        ar <= bus.i_divisor == '0 ? bus.i_dividend : bus.i_dividend % bus.i_divisor;
      end else if (state == RUN) begin
        quo <= quo_n;
        rem <= rem_n;
        cnt <= cnt - CW'(1);
        if (done) begin
          q_out <= ABSTRACT_MODEL ? aq : quo_n;
          r_out <= ABSTRACT_MODEL ? ar : rem_n[WIDTH-1:0];
`ifdef DIVIDER_FSM_DIVZERO_EN
          dz <= dvs == '0;
`endif
        end
      end
    end
  assign bus.o_busy = state == RUN;
  assign bus.o_quotient = q_out;
  assign bus.o_remainder = r_out;
endmodule

// File: tb/tb_divider_fsm.sv
// tb_divider_fsm: directed vector table, multi-cycle corner sequences, and a random cross-check of both models.
module tb_divider_fsm;
  logic clk = 1'b0;
  logic rst, cg, beg;
  logic [7:0] dd, dv;
  int errors = 0;
  int checks = 0;
  divider_fsm_if #(.WIDTH(8)) a ();
  divider_fsm_if #(.WIDTH(8)) b ();
  assign a.i_cg = cg;
  assign b.i_cg = cg;
  assign a.i_begin = beg;
  assign b.i_begin = beg;
  assign a.i_dividend = dd;
  assign b.i_dividend = dd;
  assign a.i_divisor = dv;
  assign b.i_divisor = dv;
  divider_fsm #(.WIDTH(8), .ABSTRACT_MODEL(1'b0)) dut_rtl (.i_clk(clk), .i_rst(rst), .bus(a));
  divider_fsm #(.WIDTH(8), .ABSTRACT_MODEL(1'b1)) dut_abs (.i_clk(clk), .i_rst(rst), .bus(b));
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] dd, dv, q, r;
    logic dz;
  } vec_t;
  vec_t vecs[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (a.o_busy && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (a.o_busy) chk("idle_timeout", 1, 0);
  endtask

  task automatic run_div(input logic [7:0] x, input logic [7:0] y, input int gap,
                         input logic [7:0] eq, input logic [7:0] er, input logic edz, input string nm);
    int n = 0;
    wait_idle();
    dd = x;
    dv = y;
    beg = 1'b1;
    @(negedge clk);
    beg = 1'b0;
    dd = 8'hA5;
    dv = 8'h5A;
    while (a.o_busy && n < 50) begin
      n++;
      cg = (n < 2 || n >= 2 + gap);
      @(negedge clk);
    end
    cg = 1'b1;
    chk({nm, "_busy_cycles"}, n, 8 + gap);
    chk({nm, "_q"}, a.o_quotient, eq);
    chk({nm, "_r"}, a.o_remainder, er);
    chk({nm, "_q_abs"}, b.o_quotient, eq);
    chk({nm, "_r_abs"}, b.o_remainder, er);
`ifdef DIVIDER_FSM_DIVZERO_EN
    chk({nm, "_dz"}, a.o_divZero, edz);
    chk({nm, "_dz_abs"}, b.o_divZero, edz);
`else
    if (edz === 1'bx) chk({nm, "_dz"}, 0, 1);
`endif
  endtask

  initial begin
    logic [7:0] eq, er;
    bit pend, pb;
    vecs[0] = '{8'd100, 8'd7, 8'd14, 8'd2, 1'b0};
    vecs[1] = '{8'd5, 8'd0, 8'd255, 8'd5, 1'b1};
    vecs[2] = '{8'd3, 8'd200, 8'd0, 8'd3, 1'b0};
    vecs[3] = '{8'd255, 8'd1, 8'd255, 8'd0, 1'b0};
    vecs[4] = '{8'd0, 8'd5, 8'd0, 8'd0, 1'b0};
    vecs[5] = '{8'd255, 8'd255, 8'd1, 8'd0, 1'b0};
    vecs[6] = '{8'd128, 8'd16, 8'd8, 8'd0, 1'b0};
    vecs[7] = '{8'd254, 8'd3, 8'd84, 8'd2, 1'b0};
    rst = 1'b1;
    cg = 1'b1;
    beg = 1'b0;
    dd = '0;
    dv = '0;
    repeat (20) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", a.o_busy, 0);
    chk("rst_q", a.o_quotient, 0);
    chk("rst_r", a.o_remainder, 0);
    chk("rst_busy_abs", b.o_busy, 0);
    foreach (vecs[i]) run_div(vecs[i].dd, vecs[i].dv, 0, vecs[i].q, vecs[i].r, vecs[i].dz, $sformatf("vec%0d", i));
    repeat (5) @(negedge clk);
    chk("hold_q", a.o_quotient, 84);
    chk("hold_r", a.o_remainder, 2);
    run_div(8'd100, 8'd7, 3, 8'd14, 8'd2, 1'b0, "gated");
    // second start while busy must be ignored
    dd = 8'd200;
    dv = 8'd9;
    beg = 1'b1;
    @(negedge clk);
    beg = 1'b0;
    @(negedge clk);
    dd = 8'd10;
    dv = 8'd3;
    beg = 1'b1;
    @(negedge clk);
    beg = 1'b0;
    wait_idle();
    chk("ignore_q", a.o_quotient, 22);
    chk("ignore_r", a.o_remainder, 2);
    chk("ignore_q_abs", b.o_quotient, 22);
    @(negedge clk);
    chk("ignore_no_restart", a.o_busy, 0);
    // asynchronous reset in the middle of a division
    dd = 8'd100;
    dv = 8'd7;
    beg = 1'b1;
    @(negedge clk);
    beg = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_busy_before", a.o_busy, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", a.o_busy, 0);
    chk("mid_rst_q", a.o_quotient, 0);
    chk("mid_rst_r", a.o_remainder, 0);
    chk("mid_rst_busy_abs", b.o_busy, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_div(8'd77, 8'd5, 0, 8'd15, 8'd2, 1'b0, "after_rst");
    pend = 0;
    pb = 0;
    eq = '0;
    er = '0;
    for (int c = 0; c < 3000; c++) begin
      if (a.o_busy !== b.o_busy) chk("rand_busy_match", a.o_busy, b.o_busy);
      else checks++;
      if (pb && !a.o_busy && pend) begin
        chk("rand_q", a.o_quotient, eq);
        chk("rand_r", a.o_remainder, er);
        chk("rand_q_abs", b.o_quotient, eq);
        chk("rand_r_abs", b.o_remainder, er);
        pend = 0;
      end
      pb = a.o_busy;
      cg = $urandom_range(0, 3) != 0;
      beg = !a.o_busy && $urandom_range(0, 9) == 0;
      dd = 8'($urandom);
      dv = $urandom_range(0, 3) == 0 ? 8'($urandom_range(0, 3)) : 8'($urandom);
      if (beg && cg) begin
        eq = dv == 0 ? 8'd255 : dd / dv;
        er = dv == 0 ? dd : dd % dv;
        pend = 1;
      end
      @(negedge clk);
    end
    beg = 1'b0;
    cg = 1'b1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
